// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words with valid/ready on both sides.
// in_last closes a partial word early; out_keep marks the occupied byte lanes.
module byte_word_packer #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_word,
   output logic [3:0]  out_keep,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] word_count
);

   logic [1:0]  lane_idx;
   logic [23:0] acc;
   logic [23:0] acc_next;
   logic [31:0] log_word;
   logic [3:0]  log_keep;
   logic [31:0] phy_word;
   logic [3:0]  phy_keep;
   logic        accept;
   logic        close;
   logic        drain;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign close    = accept && ((lane_idx == 2'd3) || in_last);
   assign drain    = out_valid && out_ready;

   // Word in logical lane order, then mapped to physical byte positions.
   always_comb begin
      log_word = 32'h0000_0000;
      log_keep = 4'b0000;
      acc_next = acc;
      case (lane_idx)
         2'd0: begin
            log_word       = {24'h00_0000, in_byte};
            log_keep       = 4'b0001;
            acc_next[7:0]  = in_byte;
         end
         2'd1: begin
            log_word       = {16'h0000, in_byte, acc[7:0]};
            log_keep       = 4'b0011;
            acc_next[15:8] = in_byte;
         end
         2'd2: begin
            log_word        = {8'h00, in_byte, acc[15:0]};
            log_keep        = 4'b0111;
            acc_next[23:16] = in_byte;
         end
         2'd3: begin
            log_word = {in_byte, acc};
            log_keep = 4'b1111;
         end
         default: begin
            log_word = 32'h0000_0000;
            log_keep = 4'b0000;
            acc_next = acc;
         end
      endcase
      if (BIG_ENDIAN) begin
         phy_word = {log_word[7:0], log_word[15:8], log_word[23:16], log_word[31:24]};
         phy_keep = {log_keep[0], log_keep[1], log_keep[2], log_keep[3]};
      end else begin
         phy_word = log_word;
         phy_keep = log_keep;
      end
   end

   // Accumulator, output register and word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_idx   <= 2'd0;
         acc        <= 24'h00_0000;
         out_word   <= 32'h0000_0000;
         out_keep   <= 4'b0000;
         out_last   <= 1'b0;
         out_valid  <= 1'b0;
         word_count <= 16'h0000;
      end else begin
         if (close) begin
            out_word  <= phy_word;
            out_keep  <= phy_keep;
            out_last  <= in_last;
            out_valid <= 1'b1;
            lane_idx  <= 2'd0;
            acc       <= 24'h00_0000;
         end else begin
            if (accept) begin
               acc      <= acc_next;
               lane_idx <= lane_idx + 2'd1;
            end
            if (drain) begin
               out_valid <= 1'b0;
            end
         end
         if (drain) begin
            word_count <= word_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: little- and big-endian instances share
// one stimulus stream; expected values are hand-computed constants.
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic        in_ready, in_ready_be;
   logic [31:0] out_word, out_word_be;
   logic [3:0]  out_keep, out_keep_be;
   logic        out_last, out_last_be;
   logic        out_valid, out_valid_be;
   logic [15:0] word_count, word_count_be;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   byte_word_packer #(.BIG_ENDIAN(1'b0)) dut_le (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
      .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .word_count(word_count)
   );

   byte_word_packer #(.BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready_be), .out_word(out_word_be),
      .out_keep(out_keep_be), .out_last(out_last_be), .out_valid(out_valid_be),
      .out_ready(out_ready), .word_count(word_count_be)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b, input logic l);
      in_valid = 1'b1;
      in_byte  = b;
      in_last  = l;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      #12;
      check_val("rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_word",  out_word, 32'h0000_0000);
      check_val("rst_keep",  {28'd0, out_keep}, 32'd0);
      check_val("rst_count", {16'd0, word_count}, 32'd0);
      check_val("rst_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // Full word, both endiannesses
      put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b0);
      check_val("le_valid", {31'd0, out_valid}, 32'd1);
      check_val("le_word",  out_word, 32'h4433_2211);
      check_val("le_keep",  {28'd0, out_keep}, 32'hF);
      check_val("le_last",  {31'd0, out_last}, 32'd0);
      check_val("be_word",  out_word_be, 32'h1122_3344);
      check_val("be_keep",  {28'd0, out_keep_be}, 32'hF);
      idle();
      check_val("le_drain", {31'd0, out_valid}, 32'd0);
      check_val("le_count", {16'd0, word_count}, 32'd1);

      // Partial flush
      put(8'hAA, 1'b0); put(8'hBB, 1'b1);
      check_val("pf_word",   out_word, 32'h0000_BBAA);
      check_val("pf_keep",   {28'd0, out_keep}, 32'h3);
      check_val("pf_last",   {31'd0, out_last}, 32'd1);
      check_val("pf_be_word", out_word_be, 32'hAABB_0000);
      check_val("pf_be_keep", {28'd0, out_keep_be}, 32'hC);
      idle();
      check_val("pf_count", {16'd0, word_count}, 32'd2);

      // Back-pressure
      put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b0); put(8'h04, 1'b0);
      check_val("bp_w1", out_word, 32'h0403_0201);
      check_val("bp_w1_last", {31'd0, out_last}, 32'd0);
      idle();
      out_ready = 1'b0;
      put(8'h05, 1'b0); put(8'h06, 1'b0); put(8'h07, 1'b0);
      check_val("bp_ready_pre", {31'd0, in_ready}, 32'd1);
      put(8'h08, 1'b0);
      check_val("bp_valid",  {31'd0, out_valid}, 32'd1);
      check_val("bp_word",   out_word, 32'h0807_0605);
      check_val("bp_stall",  {31'd0, in_ready}, 32'd0);
      put(8'h09, 1'b1);
      tick();
      check_val("bp_hold_word",  out_word, 32'h0807_0605);
      check_val("bp_hold_keep",  {28'd0, out_keep}, 32'hF);
      check_val("bp_hold_count", {16'd0, word_count}, 32'd3);
      out_ready = 1'b1;
      #1;
      check_val("bp_ready_comb", {31'd0, in_ready}, 32'd1);
      tick();
      check_val("bp_sim_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_sim_word",  out_word, 32'h0000_0009);
      check_val("bp_sim_keep",  {28'd0, out_keep}, 32'h1);
      check_val("bp_sim_count", {16'd0, word_count}, 32'd4);
      put(8'h0A, 1'b1);
      check_val("bp_sim2_word",  out_word, 32'h0000_000A);
      check_val("bp_sim2_count", {16'd0, word_count}, 32'd5);
      idle();
      check_val("bp_end_valid", {31'd0, out_valid}, 32'd0);
      check_val("bp_end_count", {16'd0, word_count}, 32'd6);

      // Asynchronous reset mid-word
      put(8'h55, 1'b0); put(8'h66, 1'b0);
      put(8'h77, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("ar_valid", {31'd0, out_valid}, 32'd0);
      check_val("ar_word",  out_word, 32'h0000_0000);
      check_val("ar_count", {16'd0, word_count}, 32'd0);
      check_val("ar_ready", {31'd0, in_ready}, 32'd1);
      #1;
      rst_n = 1'b1;
      tick();
      put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b0); put(8'h04, 1'b0);
      check_val("ar_word2", out_word, 32'h0403_0201);
      check_val("ar_keep2", {28'd0, out_keep}, 32'hF);
      idle();
      check_val("ar_count2", {16'd0, word_count}, 32'd1);

      // Counter wrap: one single-byte word per cycle from a fresh reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_last = 1'b1; in_byte = 8'h5A;
      for (int i = 1; i <= 65536; i++) begin
         tick();
         if (i == 1000) check_val("wr_mid", {16'd0, word_count}, 32'd999);
      end
      check_val("wr_ffff", {16'd0, word_count}, 32'h0000_FFFF);
      tick();
      check_val("wr_zero", {16'd0, word_count}, 32'h0000_0000);
      check_val("wr_word", out_word, 32'h0000_005A);
      in_valid = 1'b0; in_last = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
